// File: rtl/special_register_pkg.sv
// Shared constants for the 4-bit multi-function register: width and opcode encodings.
package special_register_pkg;

  localparam int unsigned W = 4;

  localparam logic [0:3] OP_SHR  = 4'd0;
  localparam logic [0:3] OP_SHL  = 4'd1;
  localparam logic [0:3] OP_LOAD = 4'd2;
  localparam logic [0:3] OP_CLR  = 4'd3;
  localparam logic [0:3] OP_SET  = 4'd4;
  localparam logic [0:3] OP_INC  = 4'd5;
  localparam logic [0:3] OP_DEC  = 4'd6;
  localparam logic [0:3] OP_NOT  = 4'd7;
  localparam logic [0:3] OP_ROR  = 4'd8;
  localparam logic [0:3] OP_ROL  = 4'd9;
  localparam logic [0:3] OP_ASR  = 4'd10;
  localparam logic [0:3] OP_NEG  = 4'd11;
  localparam logic [0:3] OP_HOLD = 4'd12;
  localparam logic [0:3] OP_AND  = 4'd13;
  localparam logic [0:3] OP_OR   = 4'd14;
  localparam logic [0:3] OP_XOR  = 4'd15;

endpackage

// File: rtl/special_register_next.sv
// Combinational next-state function: computes next Q and serial output from the current state.
module special_register_next
  import special_register_pkg::*;
(
  input  logic [0:W-1] q,
  input  logic         sout,
  input  logic [0:3]   sel,
  input  logic [0:W-1] pin,
  input  logic         sin,
  output logic [0:W-1] q_next,
  output logic         sout_next
);

  // Bit 0 is the MSB, so "right" moves data toward bit W-1.
  always_comb begin
    q_next    = q;
    sout_next = sout;
    case (sel)
      OP_SHR: begin
        q_next    = {sin, q[0:W-2]};
        sout_next = q[W-1];
      end
      OP_SHL: begin
        q_next    = {q[1:W-1], sin};
        sout_next = q[0];
      end
      OP_LOAD: q_next = pin;
      OP_CLR:  q_next = '0;
      OP_SET:  q_next = '1;
      OP_INC:  q_next = q + 4'd1;
      OP_DEC:  q_next = q - 4'd1;
      OP_NOT:  q_next = ~q;
      OP_ROR: begin
        q_next    = {q[W-1], q[0:W-2]};
        sout_next = q[W-1];
      end
      OP_ROL: begin
        q_next    = {q[1:W-1], q[0]};
        sout_next = q[0];
      end
      OP_ASR: begin
        q_next    = {q[0], q[0:W-2]};
        sout_next = q[W-1];
      end
      OP_NEG:  q_next = ~q + 4'd1;
      OP_HOLD: q_next = q;
      OP_AND:  q_next = q & pin;
      OP_OR:   q_next = q | pin;
      OP_XOR:  q_next = q ^ pin;
      // X/Z on sel falls through here and holds state in simulation.
      default: begin
        q_next    = q;
        sout_next = sout;
      end
    endcase
  end

endmodule

// File: rtl/special_register.sv
// 4-bit multi-function register: asynchronous-reset storage for Q and the serial output.
module special_register
  import special_register_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [0:3]   sel,
  input  logic [0:W-1] PIn,
  input  logic         SIn,
  output logic [0:W-1] POut,
  output logic         SOut
);

  logic [0:W-1] q_q, q_d;
  logic         sout_q, sout_d;

  special_register_next u_next (
    .q         (q_q),
    .sout      (sout_q),
    .sel       (sel),
    .pin       (PIn),
    .sin       (SIn),
    .q_next    (q_d),
    .sout_next (sout_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

  assign POut = q_q;
  assign SOut = sout_q;

endmodule

// File: tb/tb_special_register.sv
// Scoreboard bench for special_register: directed plan plus random opcodes vs. an arithmetic model.
module tb_special_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:3] sel = 4'd12;
  logic [0:3] PIn = 4'd0;
  logic       SIn = 1'b0;
  logic [0:3] POut;
  logic       SOut;

  int checks = 0;
  int errors = 0;
  int m_q = 0;
  int m_s = 0;
  int exp_q[$];
  int exp_s[$];

  special_register dut (
    .clk  (clk),
    .rst  (rst),
    .sel  (sel),
    .PIn  (PIn),
    .SIn  (SIn),
    .POut (POut),
    .SOut (SOut)
  );

  always #5 clk = ~clk;

  // Reference model on plain integers 0..15; bit 0 of the DUT bus is the MSB (value 8).
  task automatic model(input int op, input int pin, input int sin);
    case (op)
      0:  begin m_s = m_q & 1; m_q = (sin << 3) | (m_q >> 1); end
      1:  begin m_s = (m_q >> 3) & 1; m_q = ((m_q << 1) | sin) % 16; end
      2:  m_q = pin;
      3:  m_q = 0;
      4:  m_q = 15;
      5:  m_q = (m_q + 1) % 16;
      6:  m_q = (m_q + 15) % 16;
      7:  m_q = 15 - m_q;
      8:  begin m_s = m_q & 1; m_q = ((m_q & 1) << 3) | (m_q >> 1); end
      9:  begin m_s = (m_q >> 3) & 1; m_q = ((m_q << 1) | (m_q >> 3)) % 16; end
      10: begin m_s = m_q & 1; m_q = (m_q & 8) | (m_q >> 1); end
      11: m_q = (16 - m_q) % 16;
      12: ;
      13: m_q = m_q & pin;
      14: m_q = m_q | pin;
      15: m_q = m_q ^ pin;
      default: ;
    endcase
  endtask

  task automatic step(input int op, input int pin, input int sin, input bit r);
    @(negedge clk);
    rst = r;
    sel = op[3:0];
    PIn = pin[3:0];
    SIn = sin[0];
    if (r) begin
      m_q = 0;
      m_s = 0;
    end else begin
      model(op, pin, sin);
    end
    exp_q.push_back(m_q);
    exp_s.push_back(m_s);
  endtask

  task automatic check_now(input string name, input int q, input int s);
    checks++;
    if (int'(POut) != q || int'(SOut) != s) begin
      errors++;
      $display("FAIL %s: POut=%0d SOut=%0d, required POut=%0d SOut=%0d",
               name, POut, SOut, q, s);
    end
  endtask

  // Monitor: output is valid one cycle after each issued operation.
  initial begin
    int q, s;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        q = exp_q.pop_front();
        s = exp_s.pop_front();
        check_now("edge", q, s);
      end
    end
  end

  initial begin
    #12;
    check_now("reset", 0, 0);

    // Reset release then LOAD 1001.
    step(2, 9, 0, 0);
    // Serial shift right: SIn 1, 0, 1.
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    // Count, hold and wraps.
    step(2, 9, 0, 0);
    step(5, 0, 0, 0);
    step(5, 0, 0, 0);
    step(12, 0, 0, 0);
    step(4, 0, 0, 0);
    step(5, 0, 0, 0);
    step(6, 0, 0, 0);
    // Rotate left four times from 1011.
    step(2, 11, 0, 0);
    for (int i = 0; i < 4; i++) step(9, 0, 0, 0);
    // Logic and arithmetic from stated start values.
    step(2, 3, 0, 0);
    step(11, 0, 0, 0);
    step(2, 8, 0, 0);
    step(10, 0, 0, 0);
    step(2, 10, 0, 0);
    step(15, 15, 0, 0);
    step(3, 0, 0, 0);
    step(7, 0, 0, 0);
    step(3, 0, 0, 0);
    step(11, 0, 0, 0);
    step(2, 8, 0, 0);
    step(11, 0, 0, 0);

    // Asynchronous reset in the middle of counting.
    step(2, 5, 0, 0);
    step(5, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_now("async_reset", 0, 0);
    step(5, 0, 0, 1);
    step(5, 0, 0, 1);
    step(5, 0, 0, 0);
    step(5, 0, 0, 0);

    // Random opcodes, data and serial input.
    for (int i = 0; i < 400; i++)
      step(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)), 0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
